// File: rtl/xs3_pkg.sv
// xs3_pkg: shared constants and FSM encoding for the excess-3 to BCD word decoder.
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_MIN     = 4'b0011;
    localparam logic [3:0] XS3_MAX     = 4'b1100;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/xs3_digit_dec.sv
// xs3_digit_dec: purely combinational decode of one excess-3 digit into a BCD
// nibble plus an invalid-code flag. Out-of-range codes map to BCD_INVALID.
module xs3_digit_dec
    import xs3_pkg::*;
(
    input  logic [3:0] xs3,
    output logic [3:0] bcd,
    output logic       invalid
);

    // Range check first, then subtract the offset only for legal codes.
    always_comb begin
        invalid = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
        bcd     = invalid ? BCD_INVALID : (xs3 - XS3_OFFSET);
    end

endmodule

// File: rtl/xs3_to_bcd_dec.sv
// xs3_to_bcd_dec: assembles DIGITS excess-3 digits into one packed BCD word with
// a valid/ready handshake on both sides. The first accepted digit lands in the
// most significant nibble. No input is taken while a finished word is held.
// Optional build macro XS3_STUCK0_EN adds a per-bit stuck-at-0 monitor that
// reports, every STUCK_WIN accepted digits, which in_xs3 bits never went high.
module xs3_to_bcd_dec
    import xs3_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int STUCK_WIN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_xs3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_err
`ifdef XS3_STUCK0_EN
    ,
    output logic [3:0]          stuck0
`endif
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("xs3_to_bcd_dec: DIGITS must be within 1..8");
    end
    if (STUCK_WIN < 2 || STUCK_WIN > 255) begin : g_bad_win
        $error("xs3_to_bcd_dec: STUCK_WIN must be within 2..255");
    end

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [4*DIGITS-1:0]  word;
    logic                 err;
    logic [3:0]           dig_bcd;
    logic                 dig_invalid;
    logic                 accept;
    logic                 last_digit;
    logic [4*DIGITS+3:0]  shifted;

    xs3_digit_dec u_dec (
        .xs3     (in_xs3),
        .bcd     (dig_bcd),
        .invalid (dig_invalid)
    );

    assign in_ready   = (state == COLLECT);
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));
    assign shifted    = {word, dig_bcd};
    assign out_bcd    = word;
    assign out_err    = err;

    // State register; reset always returns to collecting an empty word.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= next_state;
    end

    // Finish a word on the last digit; release it only when downstream takes it.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && last_digit) next_state = HOLD;
            HOLD:    if (out_ready)            next_state = COLLECT;
            default:                           next_state = COLLECT;
        endcase
    end

    // Shift decoded digits in from the bottom; error flag restarts with each word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
            err  <= 1'b0;
        end else if (accept) begin
            word <= shifted[4*DIGITS-1:0];
            err  <= (cnt == '0) ? dig_invalid : (err | dig_invalid);
            cnt  <= last_digit ? '0 : (cnt + 1'b1);
        end
    end

`ifdef XS3_STUCK0_EN
    localparam int WIN_W = $clog2(STUCK_WIN);

    logic [WIN_W-1:0] win_cnt;
    logic [3:0]       seen_mask;
    logic [3:0]       stuck_q;

    assign stuck0 = stuck_q;

    // Accumulate which bits were ever 1; publish the complement once per window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            seen_mask <= 4'b0000;
            stuck_q   <= 4'b0000;
        end else if (accept) begin
            if (win_cnt == WIN_W'(STUCK_WIN - 1)) begin
                stuck_q   <= ~(seen_mask | in_xs3);
                seen_mask <= 4'b0000;
                win_cnt   <= '0;
            end else begin
                seen_mask <= seen_mask | in_xs3;
                win_cnt   <= win_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xs3_to_bcd_dec.sv
// tb_xs3_to_bcd_dec: self-checking bench for xs3_to_bcd_dec (DIGITS=4).
// Directed vector table, hand-written reset/stuck-monitor sequences, then a
// randomized handshake phase scored against a word-level reference model.
// Stuck-monitor checks are compiled in when XS3_STUCK0_EN is defined.
module tb_xs3_to_bcd_dec;

    localparam int DIGITS      = 4;
    localparam int STUCK_WIN   = 16;
    localparam int NUM_RAND    = 10000;
    localparam int RAND_BUDGET = 60000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_xs3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_err;
`ifdef XS3_STUCK0_EN
    logic [3:0]  stuck0;
`endif

    xs3_to_bcd_dec #(
        .DIGITS    (DIGITS),
        .STUCK_WIN (STUCK_WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xs3    (in_xs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err)
`ifdef XS3_STUCK0_EN
        ,
        .stuck0    (stuck0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] codes;
        logic [15:0] exp_bcd;
        logic        exp_err;
        int          hold;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        err;
    } word_t;

    vec_t       vecs[6];
    word_t      exp_q[$];
    logic [3:0] pend_q[$];
    bit         mon_en  = 1'b0;
    int         acc_cnt = 0;

    // Reference decode straight from the code-range rules.
    function automatic logic [3:0] ref_dec(input logic [3:0] x);
        int v;
        v = int'(x);
        if (v >= 3 && v <= 12) return 4'(v - 3);
        return 4'hF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Feed one word back-to-back, then hold it for 'hold' cycles with out_ready=0.
    // Junk is presented on in_xs3 throughout HOLD to expose any input bypass.
    task automatic applyStimulus(input logic [15:0] codes, input logic [15:0] exp_bcd,
                                 input logic exp_err, input int hold, input string name);
        out_ready = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            in_valid = 1'b1;
            in_xs3   = codes[15-4*i -: 4];
            checkOutput({name, ".in_ready_collect"}, 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            if (i < DIGITS - 1)
                checkOutput({name, ".early_valid"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_xs3   = 4'b0000;
        checkOutput({name, ".out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, ".in_ready_hold"}, 32'(in_ready), 32'd0);
        checkOutput({name, ".out_bcd"}, 32'(out_bcd), 32'(exp_bcd));
        checkOutput({name, ".out_err"}, 32'(out_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checkOutput({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            checkOutput({name, ".hold_bcd"}, 32'(out_bcd), 32'(exp_bcd));
            checkOutput({name, ".hold_err"}, 32'(out_err), 32'(exp_err));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({name, ".released_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, ".released_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard: log accepted digits, build expected words, compare delivered words.
    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) begin
                pend_q.push_back(in_xs3);
                acc_cnt++;
                if (pend_q.size() == DIGITS) begin
                    word_t w;
                    int    b;
                    b     = 0;
                    w.err = 1'b0;
                    for (int j = 0; j < DIGITS; j++) begin
                        logic [3:0] d;
                        d = pend_q.pop_front();
                        b = b * 16 + int'(ref_dec(d));
                        if (d < 4'd3 || d > 4'd12) w.err = 1'b1;
                    end
                    w.bcd = 16'(b);
                    exp_q.push_back(w);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand.unexpected_word", 32'(out_bcd), 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    checkOutput("rand.word_bcd", 32'(out_bcd), 32'(w.bcd));
                    checkOutput("rand.word_err", 32'(out_err), 32'(w.err));
                end
            end
        end
    end

    initial begin
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_xs3    = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.out_bcd", 32'(out_bcd), 32'd0);
        checkOutput("reset.out_err", 32'(out_err), 32'd0);
`ifdef XS3_STUCK0_EN
        checkOutput("reset.stuck0", 32'(stuck0), 32'd0);
`endif
        rst = 1'b0;

        vecs[0] = '{16'h4_5_6_C, 16'h1239, 1'b0, 0, "basic"};
        vecs[1] = '{16'h3_1_C_7, 16'h0F94, 1'b1, 0, "invalid_digit"};
        vecs[2] = '{16'h7_8_9_A, 16'h4567, 1'b0, 0, "clean_after_err"};
        vecs[3] = '{16'hB_A_3_C, 16'h8709, 1'b0, 5, "hold5"};
        vecs[4] = '{16'h2_D_0_F, 16'hFFFF, 1'b1, 2, "all_invalid"};
        vecs[5] = '{16'h3_C_3_C, 16'h0909, 1'b0, 0, "range_edges"};
        for (int v = 0; v < 6; v++)
            applyStimulus(vecs[v].codes, vecs[v].exp_bcd, vecs[v].exp_err,
                          vecs[v].hold, vecs[v].name);

        // Reset mid-word: two digits in, then reset; the next word must be whole.
        in_valid = 1'b1; in_xs3 = 4'b0100;
        @(posedge clk); #1;
        in_xs3 = 4'b0101;
        @(posedge clk); #1;
        checkOutput("midreset.pre_valid", 32'(out_valid), 32'd0);
        doReset();
        checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset.out_bcd", 32'(out_bcd), 32'd0);
        applyStimulus(16'hCCCC, 16'h9999, 1'b0, 0, "after_midreset");

        // Reset while holding a finished word: it must vanish.
        for (int i = 0; i < DIGITS; i++) begin
            in_valid = 1'b1; in_xs3 = 4'b0100;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("holdreset.pre_valid", 32'(out_valid), 32'd1);
        doReset();
        checkOutput("holdreset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("holdreset.out_err", 32'(out_err), 32'd0);
        applyStimulus(16'h3456, 16'h0123, 1'b0, 0, "after_holdreset");

`ifdef XS3_STUCK0_EN
        doReset();
        applyStimulus(16'h3737, 16'h0404, 1'b0, 0, "stuck.w1");
        applyStimulus(16'h7373, 16'h4040, 1'b0, 0, "stuck.w2");
        applyStimulus(16'h3377, 16'h0044, 1'b0, 0, "stuck.w3");
        checkOutput("stuck.before_window", 32'(stuck0), 32'd0);
        applyStimulus(16'h7733, 16'h4400, 1'b0, 0, "stuck.w4");
        checkOutput("stuck.window1", 32'(stuck0), 32'b1000);
        applyStimulus(16'hC333, 16'h9000, 1'b0, 0, "stuck.w5");
        applyStimulus(16'h3333, 16'h0000, 1'b0, 0, "stuck.w6");
        applyStimulus(16'h3737, 16'h0404, 1'b0, 0, "stuck.w7");
        checkOutput("stuck.window1_held", 32'(stuck0), 32'b1000);
        applyStimulus(16'h3737, 16'h0404, 1'b0, 0, "stuck.w8");
        checkOutput("stuck.window2", 32'(stuck0), 32'b0000);
`endif

        // Randomized handshakes on both sides, scored by the monitor.
        doReset();
        mon_en = 1'b1;
        cyc    = 0;
        while (!(acc_cnt >= NUM_RAND && (acc_cnt % DIGITS) == 0) && cyc < RAND_BUDGET) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_xs3    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || out_valid) && cyc < RAND_BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        mon_en    = 1'b0;
        out_ready = 1'b0;
        checkOutput("rand.budget_ok", 32'(cyc < RAND_BUDGET), 32'd1);
        checkOutput("rand.words_left", 32'(exp_q.size()), 32'd0);
        checkOutput("rand.digits_left", 32'(pend_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
